// File: rtl/sblk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sblk_pkg
//  Description : Shared types and constants for the sblk row feeder.
//                Instruction field widths, feeder FSM states and the
//                default-shaped command record.
//  Revision    : 1.0 - initial release
// ============================================================================
package sblk_pkg;

    // Instruction word fields: TN, TM, TP, LN, LP
    localparam int WID_INST_TN = 3;
    localparam int WID_INST_TM = 3;
    localparam int WID_INST_TP = 2;
    localparam int WID_INST_LN = 3;
    localparam int WID_INST_LP = 3;
    localparam int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP
                               + WID_INST_LN + WID_INST_LP;

    // Shape of a command for the default row-array configuration
    localparam int CMD_N_ROW   = 3;
    localparam int CMD_WID_LEN = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    typedef struct packed {
        logic [WID_INST-1:0]    inst;
        logic [CMD_N_ROW-1:0]   mask;
        logic [CMD_WID_LEN-1:0] len;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/sblk_row_hold.sv
`default_nettype none
// ============================================================================
//  Module      : sblk_row_hold
//  Description : One-entry holding register driving a single sblk row's
//                activation input. A loaded beat stays valid and stable
//                until the row takes it (vld && req).
//  Ports       : clk_l, rst    clock / sync active-high reset
//                clr           wipe entry (new command accepted)
//                load, data_in load a new beat (wins over a same-cycle take)
//                req           row ready
//                vld, data     registered beat towards the row
//  Revision    : 1.0 - initial release
// ============================================================================
module sblk_row_hold #(
    parameter int WID_BEAT = 32
) (
    input  logic                clk_l,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [WID_BEAT-1:0] data_in,
    input  logic                req,
    output logic                vld,
    output logic [WID_BEAT-1:0] data
);

    always_ff @(posedge clk_l) begin
        if (rst || clr) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            data <= data_in;
        end else if (vld && req) begin
            vld  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sblk_row_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sblk_row_feeder
//  Description : Controller-side transmitter for one sblk row array.
//                Accepts a command, strobes the instruction into the masked
//                rows, broadcasts cmd_len activation beats to them in
//                lock-step, waits for their status and pulses done.
//  Ports       : clk_l, rst            clock / sync active-high reset
//                cmd_*                 command (inst, mask, len) vld/rdy
//                src_*                 upstream activation beats vld/rdy
//                act_data_in*          per-row beat, valid, ready
//                inst_data, inst_en    per-row instruction and strobe
//                status_sblk           per-row idle/finished
//                busy, done            activity flag, completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module sblk_row_feeder #(
    parameter int N_ROW    = 3,
    parameter int WID_ACT  = 16,
    parameter int WID_INST = sblk_pkg::WID_INST,
    parameter int WID_LEN  = 10,
    parameter int MIN_WAIT = 2
) (
    input  logic                          clk_l,
    input  logic                          rst,
    input  logic [WID_INST-1:0]           cmd_inst,
    input  logic [N_ROW-1:0]              cmd_mask,
    input  logic [WID_LEN-1:0]            cmd_len,
    input  logic                          cmd_vld,
    output logic                          cmd_rdy,
    input  logic [2*WID_ACT-1:0]          src_data,
    input  logic                          src_vld,
    output logic                          src_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]    act_data_in,
    output logic [N_ROW-1:0]              act_data_in_vld,
    input  logic [N_ROW-1:0]              act_data_in_req,
    output logic [WID_INST*N_ROW-1:0]     inst_data,
    output logic [N_ROW-1:0]              inst_en,
    input  logic [N_ROW-1:0]              status_sblk,
    output logic                          busy,
    output logic                          done
);

    import sblk_pkg::*;

    localparam int WID_BEAT = 2 * WID_ACT;
    localparam int WID_WAIT = $clog2(MIN_WAIT + 2);
    localparam logic [WID_WAIT-1:0] c_min_wait = WID_WAIT'(MIN_WAIT);

    feeder_state_t               r_state;
    logic [N_ROW-1:0]            r_mask;
    logic [WID_LEN-1:0]          r_beats_left;
    logic [WID_WAIT-1:0]         r_wait_cnt;

    logic                        w_cmd_acc;
    logic [N_ROW-1:0]            w_row_ok;
    logic                        w_src_rdy;
    logic                        w_beat_xfer;
    logic [N_ROW-1:0]            w_load;
    logic                        w_status_ok;
    logic [WID_INST*N_ROW-1:0]   w_inst_fan;

    always_comb begin
        w_cmd_acc   = (r_state == IDLE) && cmd_vld && cmd_rdy;
        // A row can take a new beat if it is unmasked, empty, or draining now.
        w_row_ok    = ~r_mask | ~act_data_in_vld | act_data_in_req;
        w_src_rdy   = (r_state == STREAM) && (r_beats_left != '0) && (&w_row_ok);
        w_beat_xfer = src_vld && w_src_rdy;
        w_load      = w_beat_xfer ? r_mask : '0;
        w_status_ok = ((status_sblk & r_mask) == r_mask);
    end

    // Instruction fan-out built from the incoming command so inst_data can be
    // registered on the accept edge and appear together with inst_en.
    always_comb begin
        w_inst_fan = '0;
        for (int r = 0; r < N_ROW; r++) begin
            if (cmd_mask[r]) begin
                w_inst_fan[r*WID_INST +: WID_INST] = cmd_inst;
            end
        end
    end

    assign src_rdy = w_src_rdy;

    always_ff @(posedge clk_l) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_beats_left <= '0;
            r_wait_cnt   <= '0;
            cmd_rdy      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            inst_en      <= '0;
            inst_data    <= '0;
        end else begin
            inst_en   <= '0;
            inst_data <= '0;
            done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_acc) begin
                        r_mask       <= cmd_mask;
                        r_beats_left <= cmd_len;
                        cmd_rdy      <= 1'b0;
                        busy         <= 1'b1;
                        if (cmd_mask == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state   <= ISSUE;
                            inst_en   <= cmd_mask;
                            inst_data <= w_inst_fan;
                        end
                    end else begin
                        cmd_rdy <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= (r_beats_left != '0) ? STREAM : WAIT;
                end
                STREAM: begin
                    // src_rdy already requires beats_left != 0, so no wrap.
                    if (w_beat_xfer) begin
                        r_beats_left <= r_beats_left - 1'b1;
                    end
                    if ((r_beats_left == '0) && (act_data_in_vld == '0)) begin
                        r_wait_cnt <= '0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt != c_min_wait) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end else if (w_status_ok) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    cmd_rdy <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        sblk_row_hold #(
            .WID_BEAT (WID_BEAT)
        ) u_hold (
            .clk_l   (clk_l),
            .rst     (rst),
            .clr     (w_cmd_acc),
            .load    (w_load[r]),
            .data_in (src_data),
            .req     (act_data_in_req[r]),
            .vld     (act_data_in_vld[r]),
            .data    (act_data_in[r*WID_BEAT +: WID_BEAT])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sblk_row_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sblk_row_feeder
//  Description : Directed self-checking bench for sblk_row_feeder. Cycle 0
//                of each command is the cycle cmd_vld is first presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sblk_row_feeder;

    localparam int N_ROW    = 3;
    localparam int WID_ACT  = 16;
    localparam int WID_INST = 14;
    localparam int WID_LEN  = 10;
    localparam int MIN_WAIT = 2;
    localparam int WB       = 2 * WID_ACT;

    logic                       clk_l = 1'b0;
    logic                       rst;
    logic [WID_INST-1:0]        cmd_inst;
    logic [N_ROW-1:0]           cmd_mask;
    logic [WID_LEN-1:0]         cmd_len;
    logic                       cmd_vld;
    logic                       cmd_rdy;
    logic [WB-1:0]              src_data;
    logic                       src_vld;
    logic                       src_rdy;
    logic [WB*N_ROW-1:0]        act_data_in;
    logic [N_ROW-1:0]           act_data_in_vld;
    logic [N_ROW-1:0]           act_data_in_req;
    logic [WID_INST*N_ROW-1:0]  inst_data;
    logic [N_ROW-1:0]           inst_en;
    logic [N_ROW-1:0]           status_sblk;
    logic                       busy;
    logic                       done;

    always #5 clk_l = ~clk_l;

    sblk_row_feeder #(
        .N_ROW(N_ROW), .WID_ACT(WID_ACT), .WID_INST(WID_INST),
        .WID_LEN(WID_LEN), .MIN_WAIT(MIN_WAIT)
    ) dut (
        .clk_l(clk_l), .rst(rst),
        .cmd_inst(cmd_inst), .cmd_mask(cmd_mask), .cmd_len(cmd_len),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .src_data(src_data), .src_vld(src_vld), .src_rdy(src_rdy),
        .act_data_in(act_data_in), .act_data_in_vld(act_data_in_vld),
        .act_data_in_req(act_data_in_req),
        .inst_data(inst_data), .inst_en(inst_en),
        .status_sblk(status_sblk), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-command observation record
    int              cyc;
    int              t_acc, t_inst, t_first_vld, t_done;
    int              n_xfer, n_inst, n_vld_any;
    int              xfer_t [16];
    logic [2:0]      inst_en_seen;
    logic [41:0]     inst_data_seen;
    logic [31:0]     rx   [3][16];
    int              rx_t [3][16];
    int              rx_n [3];
    int              bad_unmasked, bad_hold, wait_viol;
    logic [2:0]      prev_vld, prev_req;
    logic [95:0]     prev_data;
    logic [2:0]      cur_mask;
    int              cur_len, src_idx;
    logic [31:0]     beats [16];

    // Per-command stimulus pattern
    logic [2:0]      req_lo_mask;
    int              req_lo_from, req_lo_to;
    bit              req1_toggle;
    int              status_on;
    logic [2:0]      status_pre;
    int              wait_from, wait_to;

    function automatic logic [2:0] req_at(input int c);
        logic [2:0] r;
        r = 3'b111;
        if (c >= req_lo_from && c <= req_lo_to) r = r & ~req_lo_mask;
        if (req1_toggle) r[1] = (c % 2 == 0);
        return r;
    endfunction

    task automatic set_defaults();
        req_lo_mask = 3'b000; req_lo_from = -1; req_lo_to = -2;
        req1_toggle = 1'b0;
        status_on   = 0;      status_pre  = 3'b000;
        wait_from   = -1;     wait_to     = -2;
    endtask

    task automatic drive_inputs();
        src_vld         = (src_idx < cur_len);
        src_data        = (src_idx < 16) ? beats[src_idx] : 32'h0;
        act_data_in_req = req_at(cyc);
        status_sblk     = (cyc >= status_on) ? 3'b111 : status_pre;
    endtask

    // Called at posedge+1; samples at negedge, returns at next posedge+1.
    task automatic cycle_step();
        bit xfer_now;
        @(negedge clk_l);
        if (t_acc < 0 && cmd_vld && cmd_rdy) t_acc = cyc;
        if (inst_en != 3'b000) begin
            n_inst++; t_inst = cyc; inst_en_seen = inst_en; inst_data_seen = inst_data;
        end
        xfer_now = src_vld && src_rdy;
        if (xfer_now) begin
            if (n_xfer < 16) xfer_t[n_xfer] = cyc;
            n_xfer++;
        end
        if (act_data_in_vld != 3'b000) n_vld_any++;
        for (int r = 0; r < N_ROW; r++) begin
            if (cyc >= 1 && !cur_mask[r] && (act_data_in_vld[r] || act_data_in[r*WB +: WB] != '0))
                bad_unmasked++;
            if (prev_vld[r] && !prev_req[r] &&
                !(act_data_in_vld[r] && act_data_in[r*WB +: WB] == prev_data[r*WB +: WB]))
                bad_hold++;
            if (act_data_in_vld[r] && act_data_in_req[r]) begin
                if (rx_n[r] < 16) begin
                    rx[r][rx_n[r]]   = act_data_in[r*WB +: WB];
                    rx_t[r][rx_n[r]] = cyc;
                end
                rx_n[r]++;
                if (t_first_vld < 0) t_first_vld = cyc;
            end
        end
        if (cyc >= wait_from && cyc <= wait_to && (!busy || done || cmd_rdy)) wait_viol++;
        if (done && t_done < 0) t_done = cyc;
        prev_vld  = act_data_in_vld;
        prev_req  = act_data_in_req;
        prev_data = act_data_in;
        @(posedge clk_l);
        #1;
        cyc++;
        if (t_acc >= 0) cmd_vld = 1'b0;
        if (xfer_now) src_idx++;
        drive_inputs();
    endtask

    task automatic start_cmd(input logic [13:0] inst, input logic [2:0] mask, input int len);
        t_acc = -1; t_inst = -1; t_first_vld = -1; t_done = -1;
        n_xfer = 0; n_inst = 0; n_vld_any = 0;
        inst_en_seen = '0; inst_data_seen = '0;
        for (int r = 0; r < N_ROW; r++) rx_n[r] = 0;
        bad_unmasked = 0; bad_hold = 0; wait_viol = 0;
        prev_vld = '0; prev_req = '0; prev_data = '0;
        cur_mask = mask; cur_len = len; src_idx = 0; cyc = 0;
        cmd_inst = inst; cmd_mask = mask; cmd_len = WID_LEN'(len); cmd_vld = 1'b1;
        drive_inputs();
        src_vld = 1'b0;
    endtask

    task automatic run_to_done(input int limit);
        int k;
        k = 0;
        while (t_done < 0 && k < limit) begin
            cycle_step();
            k++;
        end
        if (t_done < 0) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [41:0] fan;
        int k;

        rst = 1'b1; cmd_inst = '0; cmd_mask = '0; cmd_len = '0; cmd_vld = 1'b0;
        src_data = '0; src_vld = 1'b0; act_data_in_req = '0; status_sblk = '0;
        set_defaults();
        repeat (3) @(posedge clk_l);
        #1;
        @(negedge clk_l);
        check_val("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        check_val("rst_busy",    64'(busy),    64'd0);
        check_val("rst_done",    64'(done),    64'd0);
        check_val("rst_inst_en", 64'(inst_en), 64'd0);
        check_val("rst_vld",     64'(act_data_in_vld), 64'd0);
        check_val("rst_act_nz",  64'(|act_data_in), 64'd0);
        check_val("rst_src_rdy", 64'(src_rdy), 64'd0);
        @(posedge clk_l); #1;
        rst = 1'b0;
        @(posedge clk_l); #1;
        @(negedge clk_l);
        check_val("rel_cmd_rdy", 64'(cmd_rdy), 64'd1);
        @(posedge clk_l); #1;

        // 1) full mask, 4 beats, everything ready
        set_defaults();
        for (int i = 0; i < 16; i++) beats[i] = 32'h1111_0000 + 32'(i);
        start_cmd(14'h2A5B, 3'b111, 4);
        run_to_done(60);
        fan = {14'h2A5B, 14'h2A5B, 14'h2A5B};
        check_val("t1_acc",       64'(t_acc), 64'd0);
        check_val("t1_inst_t",    64'(t_inst), 64'd1);
        check_val("t1_inst_en",   64'(inst_en_seen), 64'h7);
        check_val("t1_inst_data", 64'(inst_data_seen), 64'(fan));
        check_val("t1_first_vld", 64'(t_first_vld), 64'd3);
        check_val("t1_n_xfer",    64'(n_xfer), 64'd4);
        check_val("t1_xfer3_t",   64'(xfer_t[3]), 64'd5);
        for (int r = 0; r < N_ROW; r++) begin
            check_val($sformatf("t1_row%0d_n", r),  64'(rx_n[r]), 64'd4);
            check_val($sformatf("t1_row%0d_b0", r), 64'(rx[r][0]), 64'h1111_0000);
            check_val($sformatf("t1_row%0d_b3", r), 64'(rx[r][3]), 64'h1111_0003);
        end
        check_val("t1_done_t",    64'(t_done), 64'd12);

        // 2) row 1 only, req[1] toggling, beats must be held while not taken
        set_defaults();
        req1_toggle = 1'b1;
        beats[0] = 32'hA; beats[1] = 32'hB; beats[2] = 32'hC;
        start_cmd(14'h0155, 3'b010, 3);
        run_to_done(60);
        check_val("t2_inst_en",  64'(inst_en_seen), 64'h2);
        check_val("t2_row1_n",   64'(rx_n[1]), 64'd3);
        check_val("t2_row1_b0",  64'(rx[1][0]), 64'hA);
        check_val("t2_row1_b1",  64'(rx[1][1]), 64'hB);
        check_val("t2_row1_b2",  64'(rx[1][2]), 64'hC);
        check_val("t2_row0_n",   64'(rx_n[0]), 64'd0);
        check_val("t2_row2_n",   64'(rx_n[2]), 64'd0);
        check_val("t2_unmasked", 64'(bad_unmasked), 64'd0);
        check_val("t2_hold",     64'(bad_hold), 64'd0);
        check_val("t2_done_t",   64'(t_done), 64'd14);

        // 3) rows 0 and 2, row 2 stalls cycles 3..7: whole broadcast waits
        set_defaults();
        req_lo_mask = 3'b100; req_lo_from = 3; req_lo_to = 7;
        for (int i = 0; i < 16; i++) beats[i] = 32'h0000_0030 + 32'(i);
        start_cmd(14'h1111, 3'b101, 3);
        run_to_done(60);
        check_val("t3_xfer1_t",   64'(xfer_t[1]), 64'd8);
        check_val("t3_row2_b0_t", 64'(rx_t[2][0]), 64'd8);
        check_val("t3_row0_b1_t", 64'(rx_t[0][1]), 64'd9);
        check_val("t3_row0_n",    64'(rx_n[0]), 64'd3);
        check_val("t3_row2_n",    64'(rx_n[2]), 64'd3);
        check_val("t3_row0_b2",   64'(rx[0][2]), 64'h32);
        check_val("t3_row2_b2",   64'(rx[2][2]), 64'h32);
        check_val("t3_row1_n",    64'(rx_n[1]), 64'd0);
        check_val("t3_hold",      64'(bad_hold), 64'd0);
        check_val("t3_done_t",    64'(t_done), 64'd16);

        // 4a) zero-length command on row 0
        set_defaults();
        start_cmd(14'h1234, 3'b001, 0);
        run_to_done(40);
        fan = {28'h0, 14'h1234};
        check_val("t4a_inst_en",   64'(inst_en_seen), 64'h1);
        check_val("t4a_inst_data", 64'(inst_data_seen), 64'(fan));
        check_val("t4a_no_vld",    64'(n_vld_any), 64'd0);
        check_val("t4a_done_t",    64'(t_done), 64'd6);

        // 4b) empty mask: straight to done, no instruction strobe
        set_defaults();
        start_cmd(14'h3FFF, 3'b000, 5);
        run_to_done(40);
        check_val("t4b_n_inst",  64'(n_inst), 64'd0);
        check_val("t4b_no_vld",  64'(n_vld_any), 64'd0);
        check_val("t4b_done_t",  64'(t_done), 64'd2);

        // 6) status partially set (unmasked row 2 and row 0) for 20 WAIT cycles
        set_defaults();
        status_pre = 3'b101; status_on = 25; wait_from = 5; wait_to = 24;
        for (int i = 0; i < 16; i++) beats[i] = 32'h0000_0060 + 32'(i);
        start_cmd(14'h0AAA, 3'b011, 1);
        run_to_done(80);
        check_val("t6_wait_flags", 64'(wait_viol), 64'd0);
        check_val("t6_row0_n",     64'(rx_n[0]), 64'd1);
        check_val("t6_row1_n",     64'(rx_n[1]), 64'd1);
        check_val("t6_done_t",     64'(t_done), 64'd27);

        // 5) reset in the middle of an 8-beat stream, then a clean command
        set_defaults();
        for (int i = 0; i < 16; i++) beats[i] = 32'h0000_0050 + 32'(i);
        start_cmd(14'h0F0F, 3'b111, 8);
        k = 0;
        while (n_xfer < 2 && k < 20) begin
            cycle_step();
            k++;
        end
        check_val("t5_xfer_pre",  64'(n_xfer), 64'd2);
        check_val("t5_vld_pre",   64'(act_data_in_vld), 64'h7);
        rst = 1'b1;
        @(posedge clk_l); #1;
        @(negedge clk_l);
        check_val("t5_vld",     64'(act_data_in_vld), 64'd0);
        check_val("t5_act_nz",  64'(|act_data_in), 64'd0);
        check_val("t5_busy",    64'(busy), 64'd0);
        check_val("t5_done",    64'(done), 64'd0);
        check_val("t5_cmd_rdy", 64'(cmd_rdy), 64'd0);
        check_val("t5_inst_en", 64'(inst_en), 64'd0);
        check_val("t5_src_rdy", 64'(src_rdy), 64'd0);
        @(posedge clk_l); #1;
        rst = 1'b0; cmd_vld = 1'b0; src_vld = 1'b0;
        @(posedge clk_l); #1;
        @(negedge clk_l);
        check_val("t5_rel_cmd_rdy", 64'(cmd_rdy), 64'd1);
        @(posedge clk_l); #1;

        set_defaults();
        for (int i = 0; i < 16; i++) beats[i] = 32'h0000_0070 + 32'(i);
        start_cmd(14'h0333, 3'b110, 2);
        run_to_done(60);
        check_val("t5b_row1_n",    64'(rx_n[1]), 64'd2);
        check_val("t5b_row2_n",    64'(rx_n[2]), 64'd2);
        check_val("t5b_row2_b1",   64'(rx[2][1]), 64'h71);
        check_val("t5b_row0_n",    64'(rx_n[0]), 64'd0);
        check_val("t5b_unmasked",  64'(bad_unmasked), 64'd0);
        check_val("t5b_done_t",    64'(t_done), 64'd10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
